oam_dma: RTL
============

OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have parameter REG_ADDR, default 16'hFF46, the address of the DMA source register.
REQ-002 SHALL have parameter DEST_BASE, default 16'hFE00, the OAM base address that copies are written to.
REQ-003 SHALL have parameter XFER_LEN, default 160, the number of bytes copied per transfer.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have cpu_addr in 16, cpu_wdata in 8, cpu_we in 1, cpu_re in 1 and cpu_rdata out 8, forming the CPU-side register port.
REQ-007 SHALL have m_addr out 16, m_wdata out 8, m_we out 1 (1=write, 0=read), m_req out 1, m_ready in 1 and m_rdata in 8, forming the bus initiator port.
REQ-008 SHALL have busy out 1, high while a transfer is pending or active.
REQ-009 SHALL have done_irq out 1, a completion pulse (see Configuration).

Function
REQ-010 SHALL use states IDLE, START, READ, WRITE.
REQ-011 SHALL, on cpu_we with cpu_addr==REG_ADDR, latch cpu_wdata into src_hi, zero the byte index idx and enter START from any state.
REQ-012 SHALL hold START for exactly one cycle, then enter READ.
REQ-013 SHALL drive m_req=1, m_we=0 and m_addr={src_eff,idx} in READ, where src_eff=src_hi-8'h20 if src_hi>=8'hE0, else src_hi.
REQ-014 SHALL complete a bus transaction only in a cycle with m_req&m_ready; m_rdata is valid in that same cycle, and m_addr, m_wdata and m_we stay stable while waiting.
REQ-015 SHALL capture m_rdata into a data register on READ completion and go to WRITE.
REQ-016 SHALL drive m_req=1, m_we=1, m_addr=DEST_BASE+idx and m_wdata=the data register in WRITE.
REQ-017 SHALL, on WRITE completion, increment idx and return to READ if idx<XFER_LEN-1; otherwise go to IDLE and clear busy on the next cycle.
REQ-018 SHALL keep m_req=0 in IDLE and START.
REQ-019 SHALL hold busy=1 in START, READ and WRITE, and 0 in IDLE.
REQ-020 SHALL return src_hi on cpu_rdata combinationally when cpu_re and cpu_addr==REG_ADDR, and 8'h00 otherwise.
REQ-021 SHALL give a register write that coincides with a transaction completion priority: the completion is discarded, idx=0 and the state is START.
REQ-022 SHALL never produce an m_addr beyond DEST_BASE+XFER_LEN-1 on writes; idx is 8 bits and never wraps.
REQ-023 SHALL give a complete transfer 1 START cycle plus 2*XFER_LEN transactions; with m_ready tied high, busy lasts 1+2*XFER_LEN cycles (321 by default).

Reset
REQ-024 SHALL, on reset assertion, immediately force state IDLE, src_hi=0, idx=0, data register=0, m_req=0, m_we=0, m_addr=0, m_wdata=0, busy=0 and done_irq=0.
REQ-025 SHALL abort a transfer in progress on reset without further bus activity and without a done_irq pulse.
REQ-026 SHALL ignore register writes while reset is high.

Configuration
REQ-027 SHALL, with macro OAM_DMA_DONE_IRQ_EN defined, pulse done_irq high for exactly one cycle, in the cycle after the final WRITE completes (the same cycle busy first reads 0).
REQ-028 SHALL, without OAM_DMA_DONE_IRQ_EN, tie done_irq to 0 and include no pulse logic.

Verification
REQ-029 SHALL cover: source memory seeded with mem[16'hC000+i]=i^8'h5A, write 8'hC0 to FF46 with m_ready=1 -> 160 writes FE00..FE9F carrying i^8'h5A, busy high for 321 cycles.
REQ-030 SHALL cover: write 8'hE1 -> reads issued from 16'hC100..C19F.
REQ-031 SHALL cover: m_ready randomly low 50% of the time -> identical OAM contents, with m_addr, m_wdata and m_we held constant during every stall.
REQ-032 SHALL cover: write 8'hC0, then write 8'hD0 after 40 transactions -> one START cycle, then reads restart at D000, and final OAM equals the D000 page.
REQ-033 SHALL cover: reset asserted mid-transfer at idx=50 -> m_req=0 the same cycle, busy=0, no done_irq, and a read of FF46 returns 8'h00.
REQ-034 SHALL cover: with OAM_DMA_DONE_IRQ_EN defined -> exactly one done_irq pulse per completed transfer; without it, done_irq stays 0 throughout.

Source files
------------

// File: rtl/oam_dma.sv
// oam_dma: copies XFER_LEN bytes from a CPU-selected source page into OAM over a shared bus.
// Defining OAM_DMA_DONE_IRQ_EN enables a one-cycle done_irq pulse when a transfer finishes.
module oam_dma #(
    parameter logic [15:0] REG_ADDR  = 16'hFF46,
    parameter logic [15:0] DEST_BASE = 16'hFE00,
    parameter int          XFER_LEN  = 160
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] m_addr,
    output logic [7:0]  m_wdata,
    output logic        m_we,
    output logic        m_req,
    input  logic        m_ready,
    input  logic [7:0]  m_rdata,
    output logic        busy,
    output logic        done_irq
);
    typedef enum logic [1:0] {IDLE, START, READ, WRITE} stateT;

    stateT      state, stateNext;
    logic [7:0] srcHi, idx, dataReg, srcEff;
    logic       regWrite, lastByte;

    assign regWrite  = cpu_we && (cpu_addr == REG_ADDR);
    assign lastByte  = idx == 8'(XFER_LEN - 1);
    // Pages E0-FF alias down to C0-DF, mirroring echo RAM.
    assign srcEff    = (srcHi >= 8'hE0) ? srcHi - 8'h20 : srcHi;
    assign cpu_rdata = (cpu_re && cpu_addr == REG_ADDR) ? srcHi : 8'h00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = regWrite                       ? START :
                    state == START                 ? READ  :
                    (state == READ  && m_ready)    ? WRITE :
                    (state == WRITE && m_ready)    ? (lastByte ? IDLE : READ) :
                    state;
        m_req   = (state == READ) || (state == WRITE);
        m_we    = state == WRITE;
        m_addr  = (state == READ)  ? {srcEff, idx} :
                  (state == WRITE) ? DEST_BASE + {8'h00, idx} : 16'h0000;
        m_wdata = (state == WRITE) ? dataReg : 8'h00;
        busy    = state != IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            srcHi   <= 8'h00;
            idx     <= 8'h00;
            dataReg <= 8'h00;
        end else if (regWrite) begin
            srcHi <= cpu_wdata;
            idx   <= 8'h00;
        end else begin
            if (state == READ && m_ready)
                dataReg <= m_rdata;
            if (state == WRITE && m_ready && !lastByte)
                idx <= idx + 8'd1;
        end
    end

`ifdef OAM_DMA_DONE_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            done_irq <= 1'b0;
        else
            done_irq <= state == WRITE && m_ready && lastByte && !regWrite;
    end
`else
    assign done_irq = 1'b0;
`endif
endmodule
